go_done_seq_ctrl: RTL and testbench
===================================

Name: go_done_seq_ctrl

Overview:
- Initiator side of the go/done handshake used by our std_* primitives (std_reg write_en→done style).
- Drives N_STEPS child components one at a time, in order: asserts each child's go, waits for its done, then advances.
- Repeats the whole sequence iter_count times, then pulses its own done, so the block is itself a go/done responder to its parent.
- Sits between a parent controller and datapath registers/units in FABulous user designs.

Parameters:
- N_STEPS, 3, number of sequential child steps (≥1).
- CNT_W, 8, width of iteration counter and iter_count input.
- TIMEOUT_CYCLES, 1024, max wait cycles per step (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- go  input  1  parent go; level, held high until done is seen.
- iter_count  input  CNT_W  number of sequence repetitions; sampled on start.
- done  output  1  one-cycle completion pulse to parent.
- child_go  output  N_STEPS  one-hot go to children; bit k drives step k.
- child_done  input  N_STEPS  done from children; bit k from step k.
- step_idx  output  clog2(N_STEPS) (min 1)  index of active step.
- iter_idx  output  CNT_W  current iteration number, 0-based.
- error  output  1  step timeout flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset: async on reset_n=0. State IDLE; done=0, child_go=0, step_idx=0, iter_idx=0, error=0, latched count=0.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - child_go=0, done=0.
  - go=1 latches iter_count and clears step_idx, iter_idx and error.
  - If the latched count is 0, next state is FIN; otherwise next state is RUN.
- RUN:
  - child_go = one-hot(step_idx), combinational from state. It stays high in the same cycle child_done[step_idx] is seen.
  - On child_done[step_idx]=1:
    - If step_idx<N_STEPS-1: step_idx+1.
    - Else if iter_idx+1 == latched count: go to FIN.
    - Else: step_idx=0, iter_idx+1.
  - child_done bits of inactive steps are ignored.
  - No gap cycle is required between steps.
- FIN:
  - done=1 for exactly one cycle, child_go=0, then IDLE.
  - If go is still high on return to IDLE, a new run starts (parent must drop go after seeing done).
- Abort: go=0 during RUN goes to IDLE next edge. child_go=0 from that cycle, done is not asserted, and counters hold their values until the next start.
- Latency: with children responding one cycle after go (std_reg), done asserts in cycle 1 + 2·N_STEPS·iter_count after the go-accept cycle (cycle 0). With iter_count=0, done asserts in cycle 1.
- iter_count changes during RUN are ignored; the latched value is used.
- Counter widths: iter_idx compares against the latched CNT_W-bit count, so iter_count=2^CNT_W-1 is the maximum and never wraps.
- reset_n asserted mid-RUN: immediate return to reset values; child_go drops asynchronously.

Optional Feature:
- Macro: GO_DONE_SEQ_TIMEOUT_EN.
- Defined:
  - A per-step wait counter clears on each step entry and increments every RUN cycle without child_done[step_idx].
  - When the counter reaches TIMEOUT_CYCLES: error←1, go to FIN (done pulses normally).
  - error is sticky until the next go-accept in IDLE or reset.
- Undefined: no counter logic; error constant 0; TIMEOUT_CYCLES unused.

Test Plan:
- N_STEPS=3, iter_count=2, std_reg children (done one cycle after go) -> child_go sequence 001,010,100,001,010,100, each high 2 cycles; done high only in cycle 13; iter_idx goes 0→1.
- iter_count=0, go=1 -> child_go never asserts; done pulses in cycle 1; state returns to IDLE.
- Child 1 delays done by 5 cycles; spurious child_done[2] pulse during step 0 -> child_go[1] held 6 cycles; spurious pulse ignored; order unchanged.
- go dropped in cycle 4 of a run -> child_go=0 from cycle 5; done never asserts; next go restarts at step 0, iter 0.
- reset_n pulsed low mid-RUN -> all outputs 0 immediately; no done; FSM is in IDLE after release.
- With GO_DONE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, child 0 never done -> child_go[0] high 8 cycles, then error=1 and a done pulse; error clears on next go-accept.

Source files
------------

// File: rtl/go_done_seq_ctrl.sv
// -----------------------------------------------------------------------------
// go_done_seq_ctrl
//
// Initiator side of the go/done handshake. Drives N_STEPS children one at a
// time and in order (assert go, wait for that child's done, advance). It runs
// the whole sequence iter_count times and then pulses its own done, so the
// block is itself a go/done responder towards its parent.
//
// Optional feature macro: GO_DONE_SEQ_TIMEOUT_EN
//   Defined   : per-step wait counter; a step that waits TIMEOUT_CYCLES cycles
//               without its done sets the sticky error flag and ends the run
//               through FIN (done still pulses).
//   Undefined : no counter logic, error is constant 0.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   reset_n     in   asynchronous active-low reset
//   go          in   parent go (level, held until done is seen)
//   iter_count  in   number of sequence repetitions, sampled on start
//   done        out  one-cycle completion pulse to parent
//   child_go    out  one-hot go to children, bit k drives step k
//   child_done  in   done from children, bit k from step k
//   step_idx    out  index of the active step
//   iter_idx    out  current iteration number, 0-based
//   error       out  step timeout flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for go; go latches iter_count and clears the counters
// RUN   | child_go[step_idx] asserted, waiting for child_done[step_idx]
// FIN   | one-cycle done pulse to the parent, then back to IDLE
// -----------------------------------------------------------------------------
module go_done_seq_ctrl #(
    parameter int N_STEPS        = 3,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            go,
    input  logic [CNT_W-1:0]                                iter_count,
    output logic                                            done,
    output logic [N_STEPS-1:0]                              child_go,
    input  logic [N_STEPS-1:0]                              child_done,
    output logic [(N_STEPS > 1 ? $clog2(N_STEPS) : 1)-1:0]  step_idx,
    output logic [CNT_W-1:0]                                iter_idx,
    output logic                                            error
);

    localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     iter_next;
    logic [N_STEPS-1:0] step_sel;
    logic               step_done;
    logic               last_step;
    logic               last_iter;
    logic               timeout;

    // One-hot decode of the active step; also used to mask child_done so
    // that done bits from inactive children can never advance the sequence.
    always_comb begin
        for (int k = 0; k < N_STEPS; k++) begin
            step_sel[k] = (step_q == SW'(k));
        end
    end

    assign step_done = |(child_done & step_sel);
    assign last_step = (step_q == SW'(N_STEPS - 1));
    // One extra bit so that iter_idx+1 never wraps, even for the maximum count.
    assign iter_next = {1'b0, iter_q} + (CNT_W + 1)'(1);
    assign last_iter = (iter_next == {1'b0, count_q});

`ifdef GO_DONE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;

    // Timeout fires in the TIMEOUT_CYCLES-th waiting cycle of a step, unless
    // the child answers in that very cycle.
    assign timeout = !step_done && (wait_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = wait_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (go) begin
                    err_d = 1'b0;
                end
            end
            RUN: begin
                if (step_done) begin
                    wait_d = '0;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
                if (go && timeout) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                wait_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign error = err_q;
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        iter_d   = iter_q;
        count_d  = count_q;
        child_go = '0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    count_d = iter_count;
                    step_d  = '0;
                    iter_d  = '0;
                    state_d = (iter_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                child_go = step_sel;
                // Abort wins over a simultaneous child done: counters hold.
                if (!go) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = FIN;
                end else if (step_done) begin
                    if (!last_step) begin
                        step_d = step_q + SW'(1);
                    end else if (last_iter) begin
                        state_d = FIN;
                    end else begin
                        step_d = '0;
                        iter_d = iter_next[CNT_W-1:0];
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            iter_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            iter_q  <= iter_d;
            count_q <= count_d;
        end
    end

    assign step_idx = step_q;
    assign iter_idx = iter_q;

endmodule

// File: tb/tb_go_done_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_go_done_seq_ctrl
//
// Bench for go_done_seq_ctrl (N_STEPS=3, CNT_W=8, TIMEOUT_CYCLES=8). Children
// are modelled as responders that answer a configurable number of cycles
// after their go rises (1 = std_reg). Each vector row is expanded into a
// per-cycle expected trace pushed to a queue, popped and compared as the DUT
// runs. Reset behaviour is exercised by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_go_done_seq_ctrl;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int TMO = 8;
`ifdef GO_DONE_SEQ_TIMEOUT_EN
    localparam int TMO_EFF = TMO;
`else
    localparam int TMO_EFF = 1 << 30;
`endif

    logic         clk;
    logic         reset_n;
    logic         go;
    logic [W-1:0] iter_count;
    logic         done;
    logic [N-1:0] child_go;
    logic [N-1:0] child_done;
    logic [1:0]   step_idx;
    logic [W-1:0] iter_idx;
    logic         error;

    go_done_seq_ctrl #(
        .N_STEPS        (N),
        .CNT_W          (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .iter_count (iter_count),
        .done       (done),
        .child_go   (child_go),
        .child_done (child_done),
        .step_idx   (step_idx),
        .iter_idx   (iter_idx),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Child responders: child k answers when its go has been high dly[k]
    // cycles already (done in cycle dly[k]+1 of its go).
    int         dly [N];
    logic [7:0] ccnt [N];
    logic [N-1:0] model_done;
    logic [N-1:0] spur;

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < N; k++) begin
            if (!reset_n) begin
                ccnt[k] <= 8'd0;
            end else if (child_go[k]) begin
                ccnt[k] <= (ccnt[k] == 8'hff) ? ccnt[k] : ccnt[k] + 8'd1;
            end else begin
                ccnt[k] <= 8'd0;
            end
        end
    end

    always_comb begin
        model_done = '0;
        for (int k = 0; k < N; k++) begin
            model_done[k] = child_go[k] && (int'(ccnt[k]) == dly[k]);
        end
    end

    assign child_done = model_done | spur;

    typedef struct {
        logic [N-1:0] cg;
        logic         dn;
        logic [1:0]   st;
        logic [W-1:0] it;
        logic         er;
    } exp_t;

    typedef struct {
        logic [W-1:0] cnt;
        int           d0;
        int           d1;
        int           d2;
        int           spur_cyc;
        logic [N-1:0] spur_mask;
        int           drop_cyc;
        int           done_cyc;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs  [$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]   prev_st  = 2'd0;
    logic [W-1:0] prev_it  = '0;
    logic         prev_err = 1'b0;

    task automatic chk(input string name, input int cyc, input exp_t e);
        n_cmp++;
        if (child_go !== e.cg || done !== e.dn || step_idx !== e.st ||
            iter_idx !== e.it || error !== e.er) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got cg=%b done=%b step=%0d iter=%0d err=%b, want cg=%b done=%b step=%0d iter=%0d err=%b",
                     name, cyc, child_go, done, step_idx, iter_idx, error,
                     e.cg, e.dn, e.st, e.it, e.er);
        end
    endtask

    // Expand one vector into the per-cycle expected trace.
    task automatic build(input vec_t v);
        int d [N];
        int cyc;
        bit stop;
        bit aborted;
        bit timed;
        d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
        cyc = 0; stop = 0; aborted = 0; timed = 0;
        exp_q.push_back('{cg: 3'b000, dn: 1'b0, st: prev_st, it: prev_it, er: prev_err});
        prev_st = 2'd0;
        prev_it = '0;
        for (int i = 0; i < int'(v.cnt) && !stop; i++) begin
            for (int k = 0; k < N && !stop; k++) begin
                for (int j = 0; j <= d[k] && !stop; j++) begin
                    cyc++;
                    exp_q.push_back('{cg: 3'(1 << k), dn: 1'b0, st: 2'(k), it: 8'(i), er: 1'b0});
                    prev_st = 2'(k);
                    prev_it = 8'(i);
                    if (v.drop_cyc != 0 && cyc == v.drop_cyc) begin
                        stop = 1; aborted = 1;
                    end else if (j == TMO_EFF - 1 && j < d[k]) begin
                        stop = 1; timed = 1;
                    end
                end
            end
        end
        prev_err = timed;
        if (aborted) begin
            repeat (3) exp_q.push_back('{cg: 3'b000, dn: 1'b0, st: prev_st, it: prev_it, er: 1'b0});
        end else begin
            exp_q.push_back('{cg: 3'b000, dn: 1'b1, st: prev_st, it: prev_it, er: timed});
            exp_q.push_back('{cg: 3'b000, dn: 1'b0, st: prev_st, it: prev_it, er: timed});
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        exp_t  e;
        int    cyc;
        int    done_at;
        string name;
        name = $sformatf("vec%0d", id);
        dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2;
        build(v);
        @(negedge clk);
        cyc = 0;
        done_at = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(name, cyc, e);
            if (done === 1'b1 && done_at < 0) done_at = cyc;
            if (e.dn) go = 1'b0;
            if (cyc == 0) begin
                go = 1'b1;
                iter_count = v.cnt;
            end else if (cyc == 1) begin
                iter_count = ~v.cnt;
            end
            if (v.drop_cyc != 0 && cyc == v.drop_cyc) go = 1'b0;
            spur = (v.spur_cyc != 0 && cyc == v.spur_cyc) ? v.spur_mask : 3'b000;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (done_at != v.done_cyc) begin
            n_bad++;
            $display("FAIL %s latency: done seen in cycle %0d, want %0d", name, done_at, v.done_cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z = '{cg: 3'b000, dn: 1'b0, st: 2'd0, it: 8'd0, er: 1'b0};
        reset_n = 1'b0;
        go = 1'b0;
        iter_count = '0;
        spur = '0;
        for (int k = 0; k < N; k++) dly[k] = 1;

        //          cnt  d0   d1 d2 spur m       drop done
        vecs.push_back('{8'd2,   1,   1, 1, 0, 3'b000, 0,  13});
        vecs.push_back('{8'd0,   1,   1, 1, 0, 3'b000, 0,   1});
        vecs.push_back('{8'd2,   1,   5, 1, 1, 3'b100, 0,  21});
        vecs.push_back('{8'd2,   1,   1, 1, 0, 3'b000, 4,  -1});
        vecs.push_back('{8'd1,   1,   1, 1, 0, 3'b000, 0,   7});
        vecs.push_back('{8'd2,   1,   1, 1, 0, 3'b000, 8,  -1});
        vecs.push_back('{8'd3,   0,   0, 0, 0, 3'b000, 0,  10});
`ifdef GO_DONE_SEQ_TIMEOUT_EN
        vecs.push_back('{8'd2, 200,   1, 1, 0, 3'b000, 0,   9});
`endif
        vecs.push_back('{8'd1,   2,   0, 3, 6, 3'b011, 0,   9});
        vecs.push_back('{8'd255, 0,   0, 0, 0, 3'b000, 0, 766});

        #12;
        chk("reset_state", 0, z);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted mid-run while step 1 is active.
        for (int k = 0; k < N; k++) dly[k] = 1;
        @(negedge clk);
        go = 1'b1;
        iter_count = 8'd2;
        repeat (3) @(negedge clk);
        chk("pre_reset", 3, '{cg: 3'b010, dn: 1'b0, st: 2'd1, it: 8'd0, er: 1'b0});
        reset_n = 1'b0;
        go = 1'b0;
        #1;
        chk("async_reset", 3, z);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_reset_idle", c, z);
        end
        prev_st = 2'd0;
        prev_it = '0;
        prev_err = 1'b0;
        run_vec(100, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
